// File: rtl/stw_pkg.sv
// rtl/stw_pkg.sv - shared types and the constant vector table for the STW test controller
package stw_pkg;

  localparam int STW_WORD_SIZE   = 16;
  localparam int STW_NUM_VECTORS = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_ACK       = 3'd3,
    ST_DONE_WAIT = 3'd4,
    ST_CHECK     = 3'd5,
    ST_FIN       = 3'd6
  } stw_state_t;

  typedef struct packed {
    logic [STW_WORD_SIZE-1:0] op1;
    logic [STW_WORD_SIZE-1:0] op2;
    logic [STW_WORD_SIZE-1:0] add;
    logic [STW_WORD_SIZE-1:0] expected;
  } stw_vector_t;

  // expected = (op1 * op2 + add) mod 2^16, worked out offline so no multiplier is built
  localparam stw_vector_t STW_VECTORS [STW_NUM_VECTORS] = '{
    '{op1: 16'h0003, op2: 16'h0005, add: 16'h0007, expected: 16'h0016},
    '{op1: 16'hFFFF, op2: 16'hFFFF, add: 16'h0000, expected: 16'h0001},
    '{op1: 16'hAAAA, op2: 16'h0001, add: 16'h5555, expected: 16'hFFFF},
    '{op1: 16'h0000, op2: 16'h1234, add: 16'h0000, expected: 16'h0000}
  };

endpackage

// File: rtl/stw_handshake_timer.sv
// rtl/stw_handshake_timer.sv - per-phase cycle counter that saturates at TIMEOUT
module stw_handshake_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // clear wins over en so a phase change always restarts the count at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != CNT_W'(TIMEOUT))) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/stw_test_controller.sv
// rtl/stw_test_controller.sv - STW initiator: broadcasts test vectors to NUM_PE PEs
// and accumulates their pass/fail and timeout status into a sticky fault map.
module stw_test_controller
  import stw_pkg::*;
#(
  parameter int WORD_SIZE   = STW_WORD_SIZE,
  parameter int NUM_PE      = 16,
  parameter int NUM_VECTORS = STW_NUM_VECTORS,
  parameter int TIMEOUT     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 test_req,
  input  logic                 clear_map,
  input  logic [NUM_PE-1:0]    pe_complete,
  input  logic [NUM_PE-1:0]    pe_result,
  output logic                 STW_test_load_en,
  output logic [WORD_SIZE-1:0] STW_mult_op1,
  output logic [WORD_SIZE-1:0] STW_mult_op2,
  output logic [WORD_SIZE-1:0] STW_add_op,
  output logic [WORD_SIZE-1:0] STW_expected,
  output logic                 STW_start,
  output logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_PE-1:0]    fault_map,
  output logic                 any_fault
);

  localparam int IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  stw_state_t       state;
  stw_state_t       next_state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] load_idx;
  stw_vector_t      vec;

  logic [NUM_PE-1:0] acked;
  logic [NUM_PE-1:0] acked_now;
  logic [NUM_PE-1:0] timed_out;
  logic [NUM_PE-1:0] late_done;
  logic              all_acked;
  logic              all_done;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  // A PE counts as acknowledged once it has been seen low at any point in ACK,
  // so a fast PE that already re-raised complete is not mistaken for a stuck one.
  assign acked_now = acked | ~pe_complete;
  assign all_acked = &acked_now;
  assign all_done  = &(pe_complete | timed_out);
  assign late_done = ~(pe_complete | timed_out);

  assign load_idx = (state == ST_CHECK) ? (idx + IDX_W'(1)) : idx;
  assign vec      = STW_VECTORS[load_idx];

  stw_handshake_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    next_state  = state;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (test_req) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        next_state = ST_START;
      end
      ST_START: begin
        next_state  = ST_ACK;
        timer_clear = 1'b1;
      end
      ST_ACK: begin
        timer_en = 1'b1;
        if (all_acked || timer_expired) begin
          next_state  = ST_DONE_WAIT;
          timer_clear = 1'b1;
        end
      end
      ST_DONE_WAIT: begin
        timer_en = 1'b1;
        if (all_done || timer_expired) next_state = ST_CHECK;
      end
      ST_CHECK: begin
        next_state = (idx == LAST_IDX) ? ST_FIN : ST_LOAD;
      end
      ST_FIN: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      acked        <= '0;
      timed_out    <= '0;
      fault_map    <= '0;
      STW_mult_op1 <= '0;
      STW_mult_op2 <= '0;
      STW_add_op   <= '0;
      STW_expected <= '0;
    end else begin
      state <= next_state;

      case (state)
        ST_IDLE: begin
          idx <= '0;
          if (clear_map) fault_map <= '0;
        end
        ST_START: begin
          acked     <= '0;
          timed_out <= '0;
        end
        ST_ACK: begin
          acked <= acked_now;
          if (!all_acked && timer_expired) begin
            timed_out <= ~acked_now;
            fault_map <= fault_map | ~acked_now;
          end
        end
        ST_DONE_WAIT: begin
          if (!all_done && timer_expired) begin
            timed_out <= timed_out | late_done;
            fault_map <= fault_map | late_done;
          end
        end
        ST_CHECK: begin
          // timed-out PEs are already flagged; their result lines are meaningless
          fault_map <= fault_map | (~pe_result & ~timed_out);
          idx       <= (idx == LAST_IDX) ? '0 : (idx + IDX_W'(1));
        end
        ST_FIN: begin
          idx <= '0;
        end
        default: begin
        end
      endcase

      if (next_state == ST_LOAD) begin
        STW_mult_op1 <= WORD_SIZE'(vec.op1);
        STW_mult_op2 <= WORD_SIZE'(vec.op2);
        STW_add_op   <= WORD_SIZE'(vec.add);
        STW_expected <= WORD_SIZE'(vec.expected);
      end
    end
  end

  assign STW_test_load_en = (state == ST_LOAD);
  assign STW_start        = (state == ST_START);
  assign busy             = (state == ST_LOAD) || (state == ST_START) || (state == ST_ACK) ||
                            (state == ST_DONE_WAIT) || (state == ST_CHECK);
  assign stall            = busy;
  assign done             = (state == ST_FIN);
  assign any_fault        = |fault_map;

endmodule

// File: tb/tb_stw_test_controller.sv
// tb/tb_stw_test_controller.sv - self-checking bench for stw_test_controller
module tb_stw_test_controller;

  localparam int NPE = 16;
  localparam int NV  = 4;

  logic           clk;
  logic           rst;
  logic           test_req;
  logic           clear_map;
  logic [NPE-1:0] pe_complete;
  logic [NPE-1:0] pe_result;
  logic           STW_test_load_en;
  logic [15:0]    STW_mult_op1;
  logic [15:0]    STW_mult_op2;
  logic [15:0]    STW_add_op;
  logic [15:0]    STW_expected;
  logic           STW_start;
  logic           stall;
  logic           busy;
  logic           done;
  logic [NPE-1:0] fault_map;
  logic           any_fault;

  stw_test_controller #(
    .WORD_SIZE   (16),
    .NUM_PE      (NPE),
    .NUM_VECTORS (NV),
    .TIMEOUT     (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .test_req         (test_req),
    .clear_map        (clear_map),
    .pe_complete      (pe_complete),
    .pe_result        (pe_result),
    .STW_test_load_en (STW_test_load_en),
    .STW_mult_op1     (STW_mult_op1),
    .STW_mult_op2     (STW_mult_op2),
    .STW_add_op       (STW_add_op),
    .STW_expected     (STW_expected),
    .STW_start        (STW_start),
    .stall            (stall),
    .busy             (busy),
    .done             (done),
    .fault_map        (fault_map),
    .any_fault        (any_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference vector table, independent of the RTL package
  logic [15:0] tv_op1 [NV] = '{16'h0003, 16'hFFFF, 16'hAAAA, 16'h0000};
  logic [15:0] tv_op2 [NV] = '{16'h0005, 16'hFFFF, 16'h0001, 16'h1234};
  logic [15:0] tv_add [NV] = '{16'h0007, 16'h0000, 16'h5555, 16'h0000};
  logic [15:0] tv_exp [NV] = '{16'h0016, 16'h0001, 16'hFFFF, 16'h0000};

  // PE models: mode 0 healthy, 1 complete stuck high, 2 never re-raises complete
  int          pe_mode [NPE];
  logic [3:0]  pe_fail [NPE];
  int          pe_cnt  [NPE];
  int          cur_vec;
  int          reinit_seq = 0;
  int          seen_seq   = -1;
  logic [31:0] pe_acc;
  logic [15:0] pe_sum;

  always @(negedge clk) begin
    if (reinit_seq != seen_seq) begin
      seen_seq = reinit_seq;
      cur_vec  = -1;
      for (int p = 0; p < NPE; p++) begin
        pe_cnt[p]      = 0;
        pe_complete[p] = 1'b1;
        pe_result[p]   = 1'b1;
      end
    end else begin
      if (STW_start) cur_vec = cur_vec + 1;
      for (int p = 0; p < NPE; p++) begin
        if (pe_mode[p] == 1) begin
          pe_complete[p] = 1'b1;
        end else if (STW_start) begin
          pe_cnt[p] = 1;
        end else if (pe_cnt[p] != 0) begin
          pe_cnt[p] = pe_cnt[p] + 1;
          if (pe_cnt[p] == 3) pe_complete[p] = 1'b0;
          if (pe_cnt[p] == 5) begin
            pe_cnt[p] = 0;
            if (pe_mode[p] == 0) begin
              pe_acc = 32'(STW_mult_op1) * 32'(STW_mult_op2) + 32'(STW_add_op);
              pe_sum = pe_acc[15:0];
              if (cur_vec >= 0 && cur_vec < NV && pe_fail[p][cur_vec]) pe_sum = pe_sum ^ 16'h0001;
              pe_result[p]   = (pe_sum == STW_expected);
              pe_complete[p] = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic reinit_pes();
    reinit_seq++;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_cfg();
    for (int p = 0; p < NPE; p++) begin
      pe_mode[p] = 0;
      pe_fail[p] = 4'h0;
    end
  endtask

  // One run from request to settle; checks operands, strobe timing, latency and map.
  task automatic run_once(input string tag, input bit clr, input bit extra_req, input bit mid_clear,
                          input int exp_lat, input logic [15:0] exp_map);
    int  n;
    int  done_at;
    int  dones;
    int  busy_cnt;
    int  loads;
    bit  prev_load;
    bit  prev_start;
    logic [31:0] arith;
    @(negedge clk);
    test_req  = 1'b1;
    clear_map = clr;
    @(negedge clk);
    test_req  = 1'b0;
    clear_map = 1'b0;
    n = 1; done_at = 0; dones = 0; busy_cnt = 0; loads = 0; prev_load = 0; prev_start = 0;
    while (n <= 300 && !(done_at != 0 && n > done_at + 10)) begin
      if (busy) busy_cnt++;
      if (done) begin
        dones++;
        if (done_at == 0) done_at = n;
      end
      if (prev_load)  check({tag, "_start_after_load"}, {62'd0, STW_start, STW_test_load_en}, 64'd2);
      if (prev_start) check({tag, "_start_one_cycle"}, {63'd0, STW_start}, 64'd0);
      if (STW_test_load_en) begin
        if (loads < NV) begin
          check($sformatf("%s_op1_v%0d", tag, loads), {48'd0, STW_mult_op1}, {48'd0, tv_op1[loads]});
          check($sformatf("%s_op2_v%0d", tag, loads), {48'd0, STW_mult_op2}, {48'd0, tv_op2[loads]});
          check($sformatf("%s_add_v%0d", tag, loads), {48'd0, STW_add_op}, {48'd0, tv_add[loads]});
          check($sformatf("%s_exp_v%0d", tag, loads), {48'd0, STW_expected}, {48'd0, tv_exp[loads]});
          arith = 32'(tv_op1[loads]) * 32'(tv_op2[loads]) + 32'(tv_add[loads]);
          check($sformatf("%s_exp_arith_v%0d", tag, loads), {48'd0, STW_expected}, {48'd0, arith[15:0]});
        end
        loads++;
      end
      prev_load  = STW_test_load_en;
      prev_start = STW_start;
      test_req   = (extra_req && n == 10);
      clear_map  = (mid_clear && n == 12);
      @(negedge clk);
      n++;
    end
    test_req  = 1'b0;
    clear_map = 1'b0;
    if (done_at == 0) check({tag, "_run_timeout"}, 64'(n), 64'(0));
    check({tag, "_done_pulses"}, 64'(dones), 64'(1));
    check({tag, "_load_count"}, 64'(loads), 64'(NV));
    check({tag, "_done_latency"}, 64'(done_at), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({tag, "_fault_map"}, {48'd0, fault_map}, {48'd0, exp_map});
    check({tag, "_any_fault"}, {63'd0, any_fault}, {63'd0, (exp_map != 16'h0)});
  endtask

  typedef struct {
    bit          clr;
    int          fa_pe;
    logic [3:0]  fa_mask;
    int          fb_pe;
    logic [3:0]  fb_mask;
    int          hi_pe;
    int          lo_pe;
    bit          mid_clear;
    bit          extra_req;
    logic [15:0] exp_map;
    int          exp_lat;
  } row_t;

  row_t rows [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] model_map;
    int          lat;
    bit          any_hi;
    bit          any_lo;
    bit          clr;
    int          roll;

    rows[0] = '{1'b1, -1, 4'h0, -1, 4'h0, -1, -1, 1'b0, 1'b0, 16'h0000, 29};
    rows[1] = '{1'b0,  5, 4'h1, -1, 4'h0, -1, -1, 1'b0, 1'b0, 16'h0020, 29};
    rows[2] = '{1'b0, -1, 4'h0, -1, 4'h0, -1, -1, 1'b1, 1'b1, 16'h0020, 29};
    rows[3] = '{1'b1, -1, 4'h0, -1, 4'h0,  3, -1, 1'b0, 1'b0, 16'h0008, 53};
    rows[4] = '{1'b1, -1, 4'h0, -1, 4'h0, -1,  9, 1'b0, 1'b0, 16'h0200, 57};
    rows[5] = '{1'b0,  0, 4'h8, 15, 4'h2, -1, -1, 1'b0, 1'b0, 16'h8201, 29};

    rst = 1'b1; test_req = 1'b0; clear_map = 1'b0;
    clear_cfg();
    reinit_pes();
    @(negedge clk);
    check("reset_strobes", {58'd0, STW_test_load_en, STW_start, stall, busy, done, any_fault}, 64'd0);
    check("reset_operands", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}, 64'd0);
    check("reset_map", {48'd0, fault_map}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      clear_cfg();
      if (rows[i].fa_pe >= 0) pe_fail[rows[i].fa_pe] = rows[i].fa_mask;
      if (rows[i].fb_pe >= 0) pe_fail[rows[i].fb_pe] = rows[i].fb_mask;
      if (rows[i].hi_pe >= 0) pe_mode[rows[i].hi_pe] = 1;
      if (rows[i].lo_pe >= 0) pe_mode[rows[i].lo_pe] = 2;
      reinit_pes();
      run_once($sformatf("row%0d", i), rows[i].clr, rows[i].extra_req, rows[i].mid_clear,
               rows[i].exp_lat, rows[i].exp_map);
    end

    // clear_map alone in IDLE wipes the sticky map
    @(negedge clk);
    clear_map = 1'b1;
    @(negedge clk);
    clear_map = 1'b0;
    check("idle_clear_map", {48'd0, fault_map}, 64'd0);
    check("idle_clear_any", {62'd0, any_fault, busy}, 64'd0);

    // reset during DONE_WAIT of vector 2 abandons the run
    clear_cfg();
    pe_fail[7] = 4'h1;
    reinit_pes();
    @(negedge clk);
    test_req = 1'b1;
    @(negedge clk);
    test_req = 1'b0;
    repeat (18) @(negedge clk);
    check("pre_rst_map", {48'd0, fault_map}, 64'h0080);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_strobes", {58'd0, STW_test_load_en, STW_start, stall, busy, done, any_fault}, 64'd0);
    check("midrun_rst_operands", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}, 64'd0);
    check("midrun_rst_map", {48'd0, fault_map}, 64'd0);
    rst = 1'b0;
    clear_cfg();
    reinit_pes();
    run_once("after_rst", 1'b0, 1'b0, 1'b0, 29, 16'h0000);

    // randomized runs against a fault/latency model derived from PE behaviour
    model_map = 16'h0000;
    for (int r = 0; r < 6; r++) begin
      clear_cfg();
      any_hi = 0;
      any_lo = 0;
      clr = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (clr) model_map = 16'h0000;
      for (int p = 0; p < NPE; p++) begin
        roll = int'($urandom_range(0, 31));
        if (roll == 0) begin
          pe_mode[p] = 1; any_hi = 1;
        end else if (roll == 1) begin
          pe_mode[p] = 2; any_lo = 1;
        end else if (roll < 6) begin
          pe_fail[p] = 4'($urandom_range(1, 15));
        end
        if (pe_mode[p] != 0 || pe_fail[p] != 4'h0) model_map[p] = 1'b1;
      end
      // ACK stretches to TIMEOUT+1 cycles for a stuck-high PE; DONE_WAIT likewise for stuck-low
      lat = 1 + NV * (1 + 1 + (any_hi ? 9 : 2) + (any_lo ? 9 : (any_hi ? 1 : 2)) + 1);
      reinit_pes();
      run_once($sformatf("rand%0d", r), clr, 1'b0, 1'b0, lat, model_map);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stw_test_controller.md
Name: stw_test_controller

Overview:
- Initiator side of the per-PE self-test-and-wait (STW) interface: sequences test vectors into a group of NUM_PE MAC PEs and collects their pass/fail results into a sticky fault map.
- Each vector is broadcast to all PEs. The block pulses start, waits for every PE's complete handshake, then records the results.
- Sits beside the array's weight-proxy control. The fault map it produces is the input to proxy/repair selection.

Parameters:
- WORD_SIZE, 16, datapath width of STW operands/expected.
- NUM_PE, 16, number of PEs driven and monitored.
- NUM_VECTORS, 4, vectors per test run; indexes the package vector table.
- TIMEOUT, 8, maximum cycles per handshake phase before unresponsive PEs are declared faulty.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- test_req  in  1  pulse: start a test run.
- clear_map  in  1  pulse: clear fault_map when not busy.
- pe_complete  in  NUM_PE  STW_complete from each PE.
- pe_result  in  NUM_PE  STW_result_out from each PE; 1 = pass.
- STW_test_load_en  out  1  vector-register load strobe, broadcast.
- STW_mult_op1  out  WORD_SIZE  multiplier operand 1.
- STW_mult_op2  out  WORD_SIZE  multiplier operand 2.
- STW_add_op  out  WORD_SIZE  adder operand.
- STW_expected  out  WORD_SIZE  expected result.
- STW_start  out  1  start pulse, broadcast.
- stall  out  1  holds array dataflow while testing.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- fault_map  out  NUM_PE  sticky; 1 = PE failed any vector or timed out.
- any_fault  out  1  OR-reduction of fault_map.

Behaviour:
- Reset (sync, rst=1 at posedge) → state IDLE; all outputs 0; vector index 0; timer 0; fault_map 0. Applies mid-run too: all strobes drop the next cycle and the run is abandoned.
- Operand outputs are registered and driven from the vector table entry at the current index.
- STW_expected = (op1*op2 + add) mod 2^WORD_SIZE, precomputed in the package, not in RTL.
- FSM:
  - IDLE: if test_req → LOAD, busy=1, stall=1. test_req while busy is ignored (not queued).
  - LOAD: one cycle, STW_test_load_en=1 with vector[idx] on the operand buses → START.
  - START: one cycle, STW_start=1 → ACK; timer cleared.
  - ACK: PEs lower complete one cycle after seeing start, so pe_complete is not sampled in the START cycle. Wait until every pe_complete=0 → DONE_WAIT, timer cleared. If timer reaches TIMEOUT, PEs still showing complete=1 are set in fault_map → DONE_WAIT.
  - DONE_WAIT: wait until every non-timed-out PE has pe_complete=1 → CHECK. On TIMEOUT, PEs still at 0 are set in fault_map → CHECK.
  - CHECK: fault_map |= ~pe_result for PEs that completed. If idx==NUM_VECTORS-1 → FIN; else idx++ → LOAD.
  - FIN: one cycle, done=1, busy=0, stall=0, idx=0 → IDLE.
- Nominal per-vector latency with a healthy PE: LOAD 1 + START 1 + ACK 2 + DONE_WAIT 2 + CHECK 1 = 7 cycles.
- fault_map is sticky across runs. It is cleared only by rst, or by clear_map in IDLE. clear_map while busy is ignored.
- test_req and clear_map in the same IDLE cycle: clear first, then the run starts with a clean map.
- Timer saturates at TIMEOUT; it never wraps.
- Vector index wraps to 0 only via FIN.

Decomposition:
- Shared package stw_pkg: FSM state enum; stw_vector_t struct (op1, op2, add, expected); constant vector table STW_VECTORS[NUM_VECTORS] with values 0x0003/0x0005/0x0007/0x0016, 0xFFFF/0xFFFF/0x0000/0x0001, 0xAAAA/0x0001/0x5555/0xFFFF, 0x0000/0x1234/0x0000/0x0000.
- One natural sub-module: stw_handshake_timer (load/enable/saturate counter with timeout flag).

Test Plan:
- Healthy PE models, test_req pulse → busy high for 4×7 cycles; done pulse at cycle 29 after request; fault_map=0x0000; any_fault=0.
- PE 5 forces result_out=0 on vector 0 (expected 0x0016) → fault_map=0x0020; any_fault=1; the remaining three vectors still run.
- PE 3 never drops complete → after TIMEOUT=8 cycles in ACK, bit 3 is set; run completes; fault_map=0x0008.
- rst asserted during DONE_WAIT of vector 2 → next cycle all outputs 0, FSM in IDLE; a new test_req runs the full sequence from vector 0.
- Second test_req while busy → ignored; exactly one done pulse. clear_map in IDLE after a failing run → fault_map=0x0000.
- Check operand buses during each LOAD: exact package values are driven with STW_test_load_en=1 for exactly one cycle, and STW_start is asserted the following cycle only.
